// File: rtl/logs_voice.sv
// ---------------------------------------------------------------------------
// logs_voice
//
// One square-wave tone voice producing a single 1-bit audio line for the
// mixer. Notes arrive over a valid/ready handshake into a one-entry pending
// register. A queued note is swapped in on the exact edge the current note
// ends, so consecutive notes play without a silent gap.
//
// Ports:
//   clk          clock
//   reset        synchronous reset, active-high
//   note_valid   upstream offers a note
//   note_ready   voice can accept a note (combinational: !pend_full && !reset)
//   note_period  half-period in clk cycles; 0 = rest
//   note_dur     note length in tick strobes; 0 = zero-length note
//   tick         one-cycle duration time-base strobe
//   audio_out    registered square-wave output
//   busy         registered; high while playing or while a note is pending
// ---------------------------------------------------------------------------
module logs_voice #(
  parameter int PBITS = 12,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [PBITS-1:0] note_period,
  input  logic [DBITS-1:0] note_dur,
  input  logic             tick,
  output logic             audio_out,
  output logic             busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;

  logic             pend_full;
  logic             pend_full_next;
  logic [PBITS-1:0] pend_period;
  logic [DBITS-1:0] pend_dur;

  logic [PBITS-1:0] period_r;
  logic [PBITS-1:0] phase_cnt;
  logic [DBITS-1:0] dur_cnt;

  logic             accept;
  logic             load;
  logic             note_end;
  logic             phase_wrap;

  // Ready looks only at the registered pending flag, so a note can never be
  // accepted on the same edge the pending entry is moved into the player.
  assign note_ready = !pend_full && !reset;
  assign accept     = note_valid && note_ready;

  // Last cycle of a half-period. Only used when period_r is nonzero, so the
  // subtraction never has to represent -1.
  assign phase_wrap = (phase_cnt == (period_r - PBITS'(1)));

  // Next-state logic. A zero-length note ends on its first PLAY cycle
  // whatever tick does. A note ending with another one pending reloads on
  // the same edge and stays in PLAY.
  always_comb begin
    state_next     = state;
    load           = 1'b0;
    note_end       = 1'b0;
    pend_full_next = pend_full;

    case (state)
      IDLE: begin
        if (pend_full) begin
          load       = 1'b1;
          state_next = PLAY;
        end
      end
      PLAY: begin
        note_end = (dur_cnt == '0) || (tick && (dur_cnt == DBITS'(1)));
        if (note_end) begin
          if (pend_full) begin
            load       = 1'b1;
            state_next = PLAY;
          end else begin
            state_next = IDLE;
          end
        end
      end
    endcase

    // accept and load are mutually exclusive: accept needs an empty
    // pending entry and load needs a full one.
    if (load) begin
      pend_full_next = 1'b0;
    end else if (accept) begin
      pend_full_next = 1'b1;
    end
  end

  // State, pending register and busy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pend_full   <= 1'b0;
      pend_period <= '0;
      pend_dur    <= '0;
      busy        <= 1'b0;
    end else begin
      state     <= state_next;
      pend_full <= pend_full_next;
      if (accept) begin
        pend_period <= note_period;
        pend_dur    <= note_dur;
      end
      busy <= (state_next == PLAY) || pend_full_next;
    end
  end

  // Active note: phase counter, duration counter and the square-wave level.
  // A load restarts the waveform low with a fresh phase. Any tick on the load
  // edge is dropped because dur_cnt is overwritten.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_r  <= '0;
      phase_cnt <= '0;
      dur_cnt   <= '0;
      audio_out <= 1'b0;
    end else if (load) begin
      period_r  <= pend_period;
      dur_cnt   <= pend_dur;
      phase_cnt <= '0;
      audio_out <= 1'b0;
    end else if ((state == PLAY) && !note_end) begin
      if (tick && (dur_cnt > DBITS'(1))) begin
        dur_cnt <= dur_cnt - DBITS'(1);
      end
      if (period_r == '0) begin
        phase_cnt <= '0;
        audio_out <= 1'b0;
      end else if (phase_wrap) begin
        phase_cnt <= '0;
        audio_out <= !audio_out;
      end else begin
        phase_cnt <= phase_cnt + PBITS'(1);
      end
    end else begin
      phase_cnt <= '0;
      audio_out <= 1'b0;
    end
  end

endmodule

// File: doc/logs_voice.md
Name: logs_voice

Overview:
- Single square-wave tone voice that produces one 1-bit audio line.
- Several instances feed the mixer's `audio_in` bus; the mixer popcounts them into its PWM.
- Notes (half-period, duration) arrive over a valid/ready handshake into a one-entry holding register, so back-to-back notes play without a gap.
- Duration is counted in external tick strobes; period is counted in clock cycles.

Parameters:
- PBITS, 12, width of the half-period field (cycles).
- DBITS, 8, width of the duration field (ticks).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- note_valid  in  1  upstream offers a note.
- note_ready  out  1  voice can accept a note. Combinational: !pend_full && !reset.
- note_period  in  PBITS  half-period in clk cycles; 0 = rest (silence).
- note_dur  in  DBITS  note length in tick strobes; 0 = zero-length note.
- tick  in  1  one-cycle duration time-base strobe.
- audio_out  out  1  registered square-wave output, to the mixer.
- busy  out  1  registered; 1 while playing or while a note is pending.

Behaviour:
- Reset values:
  - audio_out=0, busy=0.
  - State=IDLE.
  - pend_full=0, phase_cnt=0, dur_cnt=0, active period=0.
  - note_ready=0 while reset is high, 1 on the first cycle after.
- Accept: on an edge with note_valid && note_ready, {note_period, note_dur} is latched into the pending register and pend_full is set.
  - No bypass: ready depends only on the registered pend_full.
  - A note cannot be accepted in the cycle the pending entry is being transferred.
- States: IDLE, PLAY.
- IDLE:
  - audio_out=0.
  - If pend_full: next edge loads pending into active (period_r, dur_cnt), clears pend_full, sets phase_cnt=0 and audio_out=0, and goes to PLAY.
  - Latency from the accept edge to the PLAY-entry edge is 1 cycle.
- PLAY, tone (period_r≥1):
  - phase_cnt increments each cycle.
  - When phase_cnt==period_r-1: phase_cnt←0 and audio_out toggles.
  - Full waveform period = 2·period_r cycles. The first 1-level begins period_r cycles after PLAY entry.
- PLAY, rest (period_r==0): audio_out held 0 and phase_cnt held 0.
- Duration:
  - In PLAY, each tick with dur_cnt>1 decrements dur_cnt.
  - A tick with dur_cnt==1 ends the note on that edge.
  - dur_cnt==0 at load ends the note on the first PLAY cycle, regardless of tick.
  - A tick coinciding with the load edge is ignored (not counted).
- Note end:
  - If pend_full: load pending into active on the same edge. Phase restarts with phase_cnt=0 and audio_out=0; stay in PLAY. No IDLE cycle.
  - Else: go to IDLE with audio_out←0 on that edge.
- busy←(next state==PLAY) || (next pend_full).
- period_r changes only at note load; note_period on the port is ignored outside accept edges.
- Wrap-around: phase_cnt never exceeds period_r-1. Maximum period_r = 2^PBITS-1 with no overflow.
- Reset asserted mid-note: on that edge, all state returns to reset values and any pending note is discarded.

Test Plan:
- Reset, then offer {period=3, dur=2}, ticks every 20 cycles:
  - note_ready=1 after reset; accepted; busy=1 next cycle.
  - audio_out is 0 for 3 cycles, then 1 for 3, repeating (period 6).
  - Returns to 0 and busy=0 on the edge of the 2nd tick after PLAY entry.
- Queue two notes: {4,1} then {2,1}.
  - Second note is accepted while the first plays, and note_ready=0 afterwards.
  - On the first note's ending tick, the voice switches directly to period 2 with audio_out=0: no IDLE cycle, busy stays 1.
- Rest note {0,3}: audio_out stays 0 for 3 ticks; busy=1 throughout, then 0.
- Zero-duration note {5,0} followed by {1,1}:
  - The first note ends after one PLAY cycle and the second loads.
  - With period 1, audio_out toggles every cycle until its tick.
- Tick on the load edge plus a max period: tick asserted exactly on the PLAY-entry edge with dur=1 is not counted; the note ends only on the next tick. Period 4095 gives toggles every 4095 cycles with no wrap glitch.
- Reset mid-note with one note pending: assert reset 1 cycle → audio_out=0, busy=0, note_ready=0 during reset and 1 after; the pending note never plays.
